uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Captures each validated byte (rdata_vld/rdata) into a DEPTH-entry synchronous FIFO.
- Presents the bytes on a first-word-fall-through valid/ready stream to the host logic.
- Counts framing/parity errors (uart_err pulses) and overflow drops in saturating counters with sticky flags.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2
CNT_WIDTH, 8, width of each saturating event counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdata_vld  in  1  one-cycle pulse, rdata holds a good byte
rdata  in  8  received byte
uart_err  in  1  one-cycle pulse, receiver flagged a framing or parity error
m_valid  out  1  FIFO head is valid
m_data  out  8  FIFO head byte
m_ready  in  1  consumer accepts the head byte this cycle
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  out  1  level == DEPTH
empty  out  1  level == 0
overflow  out  1  sticky: at least one byte dropped
err_seen  out  1  sticky: at least one uart_err
ovf_cnt  out  CNT_WIDTH  saturating count of dropped bytes
err_cnt  out  CNT_WIDTH  saturating count of uart_err pulses
clr_status  in  1  clears the sticky flags and both counters

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on rst.
- Reset values:
  - level=0, empty=1, full=0, m_valid=0.
  - m_data=0, overflow=0, err_seen=0, ovf_cnt=0, err_cnt=0.
  - Read/write pointers = 0. Memory contents are not reset.
- Reset mid-operation discards all stored bytes. The first cycle after reset behaves as empty.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Pop: pop = m_valid && m_ready.
  - Advances the read pointer.
  - m_ready while m_valid=0 is ignored.
- Push attempt: rdata_vld=1 && uart_err=0.
  - Push accepted when full=0, or when full=1 and pop=1 in the same cycle.
  - Accepted: byte is written at the write pointer and the pointer advances.
- Drop: push attempt while full=1 and pop=0.
  - Byte is discarded.
  - overflow <= 1.
  - ovf_cnt increments, saturating at 2^CNT_WIDTH-1.
- Error: uart_err=1.
  - err_seen <= 1.
  - err_cnt increments, saturating.
  - If rdata_vld is also 1 that cycle, the byte is not written; the error takes precedence.
- Level update, registered:
  - +1 on accepted push without pop.
  - -1 on pop without push.
  - Unchanged on push+pop, or when neither occurs.
  - full and empty are registered and consistent with level every cycle.
- Simultaneous push and pop when empty is impossible, since m_valid=0.
  - The push lands, and m_valid rises the next cycle.
- First-word-fall-through timing:
  - A byte accepted at cycle N into an empty FIFO gives m_valid=1 with m_data=byte at cycle N+1.
  - After a pop at cycle N, the next byte (if any) is on m_data at cycle N+1.
  - m_data is registered.
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
- Sustained throughput: one push and one pop per cycle with no bubbles once non-empty.
- clr_status:
  - Next cycle: overflow=0, err_seen=0, ovf_cnt=0, err_cnt=0.
  - If a drop or error occurs in the same cycle as clr_status, that event wins. The flag becomes 1 and the counter becomes 1.
  - Does not affect FIFO contents or level.
- Ordering: bytes leave in exactly the order they were accepted. Dropped bytes never appear.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43 with m_ready=0.
   - level=3; m_valid=1 one cycle after the first push; m_data=0x41 held.
   - Then m_ready=1: outputs 0x41, 0x42, 0x43 on consecutive cycles, then m_valid=0, empty=1.
2. m_ready=0, push 17 bytes 0x00..0x10 with DEPTH=16.
   - full=1 after byte 16; byte 0x10 dropped; overflow=1, ovf_cnt=1.
   - Drain yields 0x00..0x0F only.
3. FIFO full, m_ready=1 and push 0xAA in the same cycle.
   - Push accepted, level stays 16, ovf_cnt unchanged; 0xAA is the last byte drained.
4. Pulse uart_err 3 times, once together with rdata_vld (data 0x55).
   - err_cnt=3, err_seen=1; 0x55 never appears on m_data.
   - Assert clr_status together with a fourth uart_err: next cycle err_cnt=1, err_seen=1.
5. With CNT_WIDTH=4, force 20 overflow drops.
   - ovf_cnt saturates at 15.
   - clr_status: ovf_cnt=0, overflow=0; level is unaffected.
6. Push 5 bytes, assert rst for one cycle mid-drain.
   - Next cycle: level=0, m_valid=0, all counters and flags 0.
   - A subsequent push of 0x7E appears at m_data one cycle later.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer sitting directly behind the UART receiver.
// Accepted bytes go into a DEPTH-entry FIFO. The FIFO presents them to the
// host on a first-word-fall-through valid/ready stream with a registered head.
// Receiver errors and overflow drops are counted in saturating counters,
// and each one also sets a sticky flag.

module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdata_vld,
  input  logic [7:0]                 rdata,
  input  logic                       uart_err,
  output logic                       m_valid,
  output logic [7:0]                 m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       err_seen,
  output logic [CNT_WIDTH-1:0]       ovf_cnt,
  output logic [CNT_WIDTH-1:0]       err_cnt,
  input  logic                       clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]           mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [LW-1:0]        level_after_pop;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 m_valid_q, m_valid_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 overflow_q, overflow_d;
  logic                 err_seen_q, err_seen_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic pop;
  logic push_try;
  logic push;
  logic drop;

  // A push attempt is only a good byte without an error in the same cycle.
  // When the FIFO is full, a pop in the same cycle frees a slot for the push.
  assign pop      = m_valid_q && m_ready;
  assign push_try = rdata_vld && !uart_err;
  assign push     = push_try && (!full_q || pop);
  assign drop     = push_try && full_q && !pop;

  // Next-state for pointers, occupancy, registered head and status.
  always_comb begin
    wr_ptr_d        = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_after_pop = pop  ? level_q - LW'(1)  : level_q;
    level_d         = push ? level_after_pop + LW'(1) : level_after_pop;
    full_d          = (level_d == LW'(DEPTH));
    empty_d         = (level_d == '0);
    m_valid_d       = !empty_d;

    // The next head is the incoming byte if the FIFO empties before this push
    // lands. Otherwise it is whatever sits at the advanced read pointer.
    // With nothing left, the last value is held.
    m_data_d = m_data_q;
    if (push && (level_after_pop == '0)) begin
      m_data_d = rdata;
    end else if (level_after_pop != '0) begin
      m_data_d = mem[rd_ptr_d];
    end

    // A drop or error in the same cycle as a clear wins, so its count restarts at 1.
    overflow_d = overflow_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      ovf_cnt_d  = clr_status ? CNT_WIDTH'(1)
                 : ((&ovf_cnt_q) ? ovf_cnt_q : ovf_cnt_q + CNT_WIDTH'(1));
    end else if (clr_status) begin
      overflow_d = 1'b0;
      ovf_cnt_d  = '0;
    end

    err_seen_d = err_seen_q;
    err_cnt_d  = err_cnt_q;
    if (uart_err) begin
      err_seen_d = 1'b1;
      err_cnt_d  = clr_status ? CNT_WIDTH'(1)
                 : ((&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_WIDTH'(1));
    end else if (clr_status) begin
      err_seen_d = 1'b0;
      err_cnt_d  = '0;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; after reset the pointers and level make any
  // stale contents unreachable. Leaving it out keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= rdata;
    end
  end

  // Control and status registers with synchronous reset.
  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      overflow_q <= 1'b0;
      err_seen_q <= 1'b0;
      ovf_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      overflow_q <= overflow_d;
      err_seen_q <= err_seen_d;
      ovf_cnt_q  <= ovf_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign level    = level_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign err_seen = err_seen_q;
  assign ovf_cnt  = ovf_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (DEPTH=16, CNT_WIDTH=4).
// The bench keeps a small occupancy model to decide which bytes are accepted.
// Accepted bytes go onto a scoreboard queue. Each byte is popped and compared
// when the DUT hands it over on the m_valid/m_ready stream.

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 4;

  logic                    clk;
  logic                    rst;
  logic                    rdata_vld;
  logic [7:0]              rdata;
  logic                    uart_err;
  logic                    m_valid;
  logic [7:0]              m_data;
  logic                    m_ready;
  logic [$clog2(DEPTH):0]  level;
  logic                    full;
  logic                    empty;
  logic                    overflow;
  logic                    err_seen;
  logic [CW-1:0]           ovf_cnt;
  logic [CW-1:0]           err_cnt;
  logic                    clr_status;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  int mlevel = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdata_vld  (rdata_vld),
    .rdata      (rdata),
    .uart_err   (uart_err),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .err_seen   (err_seen),
    .ovf_cnt    (ovf_cnt),
    .err_cnt    (err_cnt),
    .clr_status (clr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: a byte is handed over whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got m_data=%02h, expected no output", m_data);
      end else begin
        if (m_data !== sb[0]) begin
          errors++;
          $display("FAIL pop_data: got %02h, expected %02h", m_data, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  // Drives one clock cycle of inputs and updates the acceptance model.
  // The inputs return to idle after the edge, and outputs are read at edge+1.
  task automatic step(input logic vld, input logic [7:0] data, input logic err,
                      input logic rdy, input logic clr);
    bit pop_m, push_m;
    rdata_vld  = vld;
    rdata      = data;
    uart_err   = err;
    m_ready    = rdy;
    clr_status = clr;
    pop_m  = (mlevel != 0) && rdy;
    push_m = vld && !err && ((mlevel < DEPTH) || pop_m);
    if (push_m) sb.push_back(data);
    mlevel = mlevel + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    @(posedge clk);
    #1;
    rdata_vld  = 1'b0;
    rdata      = 8'h00;
    uart_err   = 1'b0;
    m_ready    = 1'b0;
    clr_status = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mlevel = 0;
  endtask

  // Drains with m_ready held high and checks that it takes the expected number of cycles.
  task automatic drain(input int exp_cycles, input string name);
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (n !== exp_cycles || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_cycles: took %0d cycles with %0d left, expected %0d cycles with 0 left",
               name, n, sb.size(), exp_cycles);
    end
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1 || level !== '0) begin
      errors++;
      $display("FAIL %s_empty: valid=%b empty=%b level=%0d, expected 0 1 0", name, m_valid, empty, level);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_fifo: level=%0d empty=%b full=%b valid=%b data=%02h, expected 0 1 0 0 00",
               level, empty, full, m_valid, m_data);
    end
    checks++;
    if (overflow !== 1'b0 || err_seen !== 1'b0 || ovf_cnt !== '0 || err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_status: ovf=%b errs=%b ovf_cnt=%0d err_cnt=%0d, expected all 0",
               overflow, err_seen, ovf_cnt, err_cnt);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h41) begin
      errors++;
      $display("FAIL fwft_latency: valid=%b data=%02h, expected 1 41", m_valid, m_data);
    end
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (level !== 5'd3 || m_data !== 8'h41 || m_valid !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: level=%0d data=%02h valid=%b empty=%b, expected 3 41 1 0",
               level, m_data, m_valid, empty);
    end
    drain(3, "basic_drain");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 14 || i == 15) begin
        checks++;
        if (full !== (i == 15) || level !== 5'(i + 1)) begin
          errors++;
          $display("FAIL full_flag_%0d: full=%b level=%0d, expected %b %0d", i, full, level, i == 15, i + 1);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || ovf_cnt !== 4'd1 || level !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL drop: ovf=%b ovf_cnt=%0d level=%0d full=%b, expected 1 1 16 1",
               overflow, ovf_cnt, level, full);
    end
  endtask

  task automatic test_full_push_pop();
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd16 || ovf_cnt !== 4'd1 || full !== 1'b1 || m_data !== 8'h01) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d ovf_cnt=%0d full=%b data=%02h, expected 16 1 1 01",
               level, ovf_cnt, full, m_data);
    end
    drain(16, "full_drain");
  endtask

  task automatic test_errors();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_cnt !== 4'd3 || err_seen !== 1'b1 || m_valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL err_count: err_cnt=%0d seen=%b valid=%b level=%0d, expected 3 1 0 0",
               err_cnt, err_seen, m_valid, level);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++;
    if (err_cnt !== 4'd1 || err_seen !== 1'b1) begin
      errors++;
      $display("FAIL err_clr_race: err_cnt=%0d seen=%b, expected 1 1", err_cnt, err_seen);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_cnt !== 4'd15) begin
      errors++;
      $display("FAIL err_saturate: err_cnt=%0d, expected 15", err_cnt);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_cnt !== '0 || err_seen !== 1'b0 || overflow !== 1'b0 || ovf_cnt !== '0) begin
      errors++;
      $display("FAIL err_clear: err_cnt=%0d seen=%b ovf=%b ovf_cnt=%0d, expected 0 0 0 0",
               err_cnt, err_seen, overflow, ovf_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      if (i == 13) begin
        checks++;
        if (ovf_cnt !== 4'd14) begin
          errors++;
          $display("FAIL ovf_count_14: ovf_cnt=%0d, expected 14", ovf_cnt);
        end
      end
    end
    checks++;
    if (ovf_cnt !== 4'd15 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_saturate: ovf_cnt=%0d ovf=%b, expected 15 1", ovf_cnt, overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovf_cnt !== '0 || overflow !== 1'b0 || level !== 5'd16 || m_data !== 8'h80) begin
      errors++;
      $display("FAIL ovf_clear: ovf_cnt=%0d ovf=%b level=%0d data=%02h, expected 0 0 16 80",
               ovf_cnt, overflow, level, m_data);
    end
    step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ovf_cnt !== 4'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clr_race: ovf_cnt=%0d ovf=%b, expected 1 1", ovf_cnt, overflow);
    end
    drain(16, "sat_drain");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0, 1'b1, 1'b0);
      checks++;
      if (level !== 5'd1 || m_valid !== 1'b1 || m_data !== 8'(8'h20 + i)) begin
        errors++;
        $display("FAIL b2b_%0d: level=%0d valid=%b data=%02h, expected 1 1 %02h",
                 i, level, m_valid, m_data, 8'(8'h20 + i));
      end
    end
    drain(1, "b2b_drain");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    do_reset();
    checks++;
    if (level !== '0 || m_valid !== 1'b0 || empty !== 1'b1 || err_cnt !== '0 || err_seen !== 1'b0 ||
        ovf_cnt !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: level=%0d valid=%b empty=%b err_cnt=%0d seen=%b ovf_cnt=%0d ovf=%b, expected 0 0 1 0 0 0 0",
               level, m_valid, empty, err_cnt, err_seen, ovf_cnt, overflow);
    end
    step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h7E || level !== 5'd1) begin
      errors++;
      $display("FAIL post_reset_push: valid=%b data=%02h level=%0d, expected 1 7e 1", m_valid, m_data, level);
    end
    drain(1, "post_reset_drain");
  endtask

  initial begin
    rst        = 1'b1;
    rdata_vld  = 1'b0;
    rdata      = 8'h00;
    uart_err   = 1'b0;
    m_ready    = 1'b0;
    clr_status = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_errors();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
